// File: rtl/fb_pkg.sv
// Shared constants and types for the frame-buffer memory arbiter.
package fb_pkg;

    localparam int unsigned FB_WORDS = 384;
    localparam int unsigned ADDR_W   = 9;
    localparam int unsigned SEL_W    = 3;
    localparam int unsigned PIX_W    = 4;

    typedef enum logic {
        S_IDLE,
        S_WRITE
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [SEL_W-1:0]  sel;
        logic [PIX_W-1:0]  data;
    } wr_entry_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Write-request buffer: power-of-two FIFO with show-ahead head and occupancy count.
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  wr_entry_t                data_i,
    output wr_entry_t                head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    wr_entry_t       mem_q [Depth];
    logic [PtrW:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]   rd_ptr_q, rd_ptr_d;

    // Extra MSB on the pointers distinguishes full from empty.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[PtrW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i && !full_o) begin
            wr_ptr_d = wr_ptr_q + (PtrW+1)'(1);
        end
        if (pop_i && !empty_o) begin
            rd_ptr_d = rd_ptr_q + (PtrW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/fb_mem_arbiter.sv
// Shares one frame-memory port between display reads (absolute priority) and buffered
// pixel writes that drain outside the display's active row window.
module fb_mem_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic              clk_25,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] disp_addr,
    input  logic [SEL_W-1:0]  disp_pix_sel,
    input  logic              disp_mem_read,
    input  logic              disp_mem_row,
    output logic [PIX_W-1:0]  disp_pixel,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [SEL_W-1:0]  wr_pix_sel,
    input  logic [PIX_W-1:0]  wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [SEL_W-1:0]  mem_pix_sel,
    output logic              mem_we,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [CNT_W-1:0]  preempt_cnt,
    output logic              addr_err
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] preempt_q, preempt_d;
    logic             addr_err_q, addr_err_d;

    wr_entry_t        wr_entry, head;
    logic             full, empty, push, pop, head_err;
    logic [PtrW:0]    count;

    assign wr_entry = '{addr: wr_addr, sel: wr_pix_sel, data: wr_data};
    assign wr_ready = rst_n && !full;
    assign push     = wr_valid && wr_ready;
    assign pop      = (state_q == S_WRITE) && !disp_mem_read && !empty;
    assign head_err = (head.addr >= ADDR_W'(FB_WORDS));

    fb_wr_fifo #(
        .Depth   (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk_i   (clk_25),
        .rst_ni  (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (wr_entry),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_comb begin
        state_d    = state_q;
        preempt_d  = preempt_q;
        addr_err_d = addr_err_q;
        unique case (state_q)
            S_IDLE: begin
                // Counting the same-edge push gives the one-cycle minimum write latency.
                if ((!empty || push) && !disp_mem_row) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (disp_mem_row) begin
                    state_d = S_IDLE;
                end else if (!push && (empty || (pop && count == (PtrW+1)'(1)))) begin
                    state_d = S_IDLE;
                end
                if (disp_mem_read && !empty && preempt_q != '1) begin
                    preempt_d = preempt_q + CNT_W'(1);
                end
                if (pop && head_err) begin
                    addr_err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            preempt_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            preempt_q  <= preempt_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_comb begin
        mem_addr    = '0;
        mem_pix_sel = '0;
        mem_wdata   = '0;
        mem_we      = 1'b0;
        if (disp_mem_read) begin
            mem_addr    = disp_addr;
            mem_pix_sel = disp_pix_sel;
        end else if (state_q == S_WRITE && !empty) begin
            mem_addr    = head.addr;
            mem_pix_sel = head.sel;
            mem_wdata   = head.data;
            mem_we      = !head_err;
        end
        // The port is held quiet while reset is asserted, whatever the requesters do.
        if (!rst_n) begin
            mem_addr    = '0;
            mem_pix_sel = '0;
            mem_wdata   = '0;
            mem_we      = 1'b0;
        end
    end

    assign disp_pixel  = disp_mem_read ? mem_rdata : '0;
    assign preempt_cnt = preempt_q;
    assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed bench for fb_mem_arbiter: inputs change on the falling edge, outputs checked 1 ns later.
module tb_fb_mem_arbiter;

    logic       clk_25 = 1'b0;
    logic       rst_n;
    logic [8:0] disp_addr;
    logic [2:0] disp_pix_sel;
    logic       disp_mem_read;
    logic       disp_mem_row;
    logic [3:0] disp_pixel;
    logic       wr_valid;
    logic       wr_ready;
    logic [8:0] wr_addr;
    logic [2:0] wr_pix_sel;
    logic [3:0] wr_data;
    logic [8:0] mem_addr;
    logic [2:0] mem_pix_sel;
    logic       mem_we;
    logic [3:0] mem_wdata;
    logic [3:0] mem_rdata;
    logic [7:0] preempt_cnt;
    logic       addr_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_25 = ~clk_25;

    fb_mem_arbiter #(
        .FIFO_DEPTH    (4),
        .CNT_W         (8)
    ) dut (
        .clk_25        (clk_25),
        .rst_n         (rst_n),
        .disp_addr     (disp_addr),
        .disp_pix_sel  (disp_pix_sel),
        .disp_mem_read (disp_mem_read),
        .disp_mem_row  (disp_mem_row),
        .disp_pixel    (disp_pixel),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_pix_sel    (wr_pix_sel),
        .wr_data       (wr_data),
        .mem_addr      (mem_addr),
        .mem_pix_sel   (mem_pix_sel),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .preempt_cnt   (preempt_cnt),
        .addr_err      (addr_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(negedge clk_25);
    endtask

    task automatic push_in(input logic [8:0] a, input logic [2:0] s, input logic [3:0] d);
        wr_valid   = 1'b1;
        wr_addr    = a;
        wr_pix_sel = s;
        wr_data    = d;
    endtask

    task automatic check_wr(input string tag, input logic [8:0] a, input logic [2:0] s,
                            input logic [3:0] d);
        check({tag, "_we"},   mem_we,      1);
        check({tag, "_addr"}, mem_addr,    a);
        check({tag, "_sel"},  mem_pix_sel, s);
        check({tag, "_data"}, mem_wdata,   d);
    endtask

    initial begin
        rst_n         = 1'b0;
        disp_addr     = 9'd7;
        disp_pix_sel  = 3'd1;
        disp_mem_read = 1'b1;
        disp_mem_row  = 1'b0;
        wr_valid      = 1'b0;
        wr_addr       = '0;
        wr_pix_sel    = '0;
        wr_data       = '0;
        mem_rdata     = 4'h3;

        // Reset state: port quiet even with a display read pending.
        #2;
        check("rst_wr_ready", wr_ready,    0);
        check("rst_we",       mem_we,      0);
        check("rst_addr",     mem_addr,    0);
        check("rst_preempt",  preempt_cnt, 0);
        check("rst_addr_err", addr_err,    0);
        next();
        rst_n = 1'b1;
        disp_mem_read = 1'b0;
        #1;
        check("rel_wr_ready", wr_ready, 1);
        check("idle_addr",    mem_addr, 0);
        check("idle_pixel",   disp_pixel, 0);

        // Single write, minimum latency, exactly one cycle of mem_we.
        next(); push_in(9'd5, 3'd2, 4'hA); #1;
        check("lat_pre_we", mem_we, 0);
        next(); wr_valid = 1'b0; #1;
        check_wr("lat", 9'd5, 3'd2, 4'hA);
        next(); #1;
        check("lat_post_we",   mem_we,   0);
        check("lat_post_addr", mem_addr, 0);

        // Fill during the row window, then drain in order after the row drops.
        disp_mem_row = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next(); push_in(9'(10 + i), 3'(i), 4'(i + 1)); #1;
            check($sformatf("fill_ready%0d", i), wr_ready, (i < 4) ? 1 : 0);
            check($sformatf("fill_we%0d", i), mem_we, 0);
        end
        next(); disp_mem_row = 1'b0; #1;
        check("drain_idle_we", mem_we, 0);
        next(); #1;
        check_wr("drain0", 9'd10, 3'd0, 4'd1);
        check("drain0_ready", wr_ready, 0);
        next(); #1;
        check_wr("drain1", 9'd11, 3'd1, 4'd2);
        check("drain1_ready", wr_ready, 1);
        next(); wr_valid = 1'b0; #1;
        check_wr("drain2", 9'd12, 3'd2, 4'd3);
        next(); #1;
        check_wr("drain3", 9'd13, 3'd3, 4'd4);
        next(); #1;
        check_wr("drain4", 9'd14, 3'd4, 4'd5);
        next(); #1;
        check("drain_done_we", mem_we, 0);

        // Display read preempts a pending write; the entry is retained.
        next(); push_in(9'd20, 3'd1, 4'd3);
        next(); wr_valid = 1'b0;
        disp_mem_read = 1'b1; disp_addr = 9'd100; disp_pix_sel = 3'd6; mem_rdata = 4'h9; #1;
        check("pre_addr",  mem_addr,    100);
        check("pre_sel",   mem_pix_sel, 6);
        check("pre_we",    mem_we,      0);
        check("pre_wdata", mem_wdata,   0);
        check("pre_pixel", disp_pixel,  9);
        next(); disp_mem_read = 1'b0; #1;
        check("pre_cnt", preempt_cnt, 1);
        check_wr("pre_retry", 9'd20, 3'd1, 4'd3);
        next(); #1;
        check("pre_done_we", mem_we, 0);

        // Out-of-range address is dropped and flagged; the following write proceeds.
        next(); push_in(9'd400, 3'd0, 4'd7);
        next(); push_in(9'd30, 3'd0, 4'd4); #1;
        check("oor_we",      mem_we,   0);
        check("oor_err_pre", addr_err, 0);
        next(); wr_valid = 1'b0; #1;
        check("oor_err", addr_err, 1);
        check_wr("oor_next", 9'd30, 3'd0, 4'd4);
        next(); #1;
        check("oor_done_we",  mem_we,   0);
        check("oor_err_held", addr_err, 1);

        // Reset while three entries are buffered and one is on the port.
        disp_mem_row = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next(); push_in(9'(50 + i), 3'd0, 4'(i));
        end
        next(); wr_valid = 1'b0; disp_mem_row = 1'b0;
        next(); #1;
        check_wr("mid_wr", 9'd50, 3'd0, 4'd0);
        #1 rst_n = 1'b0; #1;
        check("mid_rst_we",   mem_we,   0);
        check("mid_rst_addr", mem_addr, 0);
        next(); rst_n = 1'b1; #1;
        check("mid_rel_ready", wr_ready, 1);
        check("mid_rel_err",   addr_err, 0);
        for (int i = 0; i < 3; i++) begin
            next(); #1;
            check($sformatf("mid_flushed%0d", i), mem_we, 0);
        end

        // 300 preemptions saturate the counter.
        next(); push_in(9'd60, 3'd5, 4'hC);
        next(); wr_valid = 1'b0; disp_mem_read = 1'b1;
        for (int i = 0; i < 300; i++) begin
            next();
        end
        #1;
        check("sat_cnt", preempt_cnt, 255);
        disp_mem_read = 1'b0; #1;
        check_wr("sat_retry", 9'd60, 3'd5, 4'hC);
        next(); #1;
        check("sat_held", preempt_cnt, 255);
        check("sat_done_we", mem_we, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
